// File: rtl/mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// mips_multicycle_core
// Multi-cycle MIPS subset core. Each instruction walks an explicit
// FETCH/DECODE/EXEC/MEM/WB state machine that advances one state per
// internal tick. The tick is a clock enable from an integrated divider, so
// everything runs in the single clk_in domain.
//
// Parameters:
//   IMEM_BYTES  instruction memory size in bytes (big-endian word fetch)
//   DMEM_WORDS  data memory size in 32-bit words (word-indexed)
//   RESULT_W    width of the result output
//   TICK_DIV    clk_in cycles per state advance (1 = every clk_in)
//
// Ports:
//   clk_in      system clock
//   reset       asynchronous, active-low reset (imem contents preserved)
//   run         level; 1 lets the core leave IDLE and keep executing
//   step        (MIPS_SINGLE_STEP_EN only) rising edge in IDLE with run=0
//               arms exactly one instruction
//   imem_we     instruction-memory byte write strobe (IDLE/HALT only)
//   imem_addr   byte address for load
//   imem_wdata  byte to write
//   result      last committed value, zero-extended/truncated to RESULT_W
//   pc_out      current PC
//   state_out   FSM state encoding (IDLE=0 .. HALT=6)
//   retire      one-clk pulse per completed instruction
//   halted      core in HALT
//   err         sticky: PC or data address out of range
//
// Optional feature macro: MIPS_SINGLE_STEP_EN (adds the step input).
// ---------------------------------------------------------------------------
module mips_multicycle_core #(
  parameter int IMEM_BYTES = 96,
  parameter int DMEM_WORDS = 100,
  parameter int RESULT_W   = 17,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          run,
`ifdef MIPS_SINGLE_STEP_EN
  input  logic                          step,
`endif
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_BYTES)-1:0] imem_addr,
  input  logic [7:0]                    imem_wdata,
  output logic [RESULT_W-1:0]           result,
  output logic [31:0]                   pc_out,
  output logic [2:0]                    state_out,
  output logic                          retire,
  output logic                          halted,
  output logic                          err
);

  localparam int IA_W  = $clog2(IMEM_BYTES);
  localparam int DA_W  = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // What EXEC decides to do with the current instruction.
  typedef enum logic [2:0] {
    K_WB   = 3'd0,  // register write in WB
    K_LD   = 3'd1,  // lw: MEM then WB
    K_ST   = 3'd2,  // sw: ends in MEM
    K_DONE = 3'd3,  // branches, jumps, unsupported: ends in EXEC
    K_SRST = 3'd4,  // soft reset opcode
    K_HALT = 3'd5   // halt opcode
  } kind_t;

  // Zero-extend or truncate a 32-bit value to RESULT_W bits.
  function automatic logic [RESULT_W-1:0] fit_result(input logic [31:0] v);
    logic [RESULT_W+31:0] wide;
    wide = {{RESULT_W{1'b0}}, v};
    return wide[RESULT_W-1:0];
  endfunction

  logic [7:0]       imem_r [IMEM_BYTES];
  logic [31:0]      dmem_r [DMEM_WORDS];
  logic [31:0]      regs_r [32];

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  state_t           state_r;
  logic [31:0]      pc_r;
  logic [31:0]      instr_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic [31:0]      imm_r;
  logic [31:0]      val_r;
  logic [31:0]      wb_res_r;
  logic [31:0]      next_pc_r;
  logic [4:0]       dest_r;
  logic [31:0]      result_r;
  logic             retire_r;
  logic             halted_r;
  logic             err_r;

  // Instruction field views of the latched instruction.
  logic [5:0]       op_s;
  logic [4:0]       rs_s;
  logic [4:0]       rt_s;
  logic [4:0]       rd_s;
  logic [4:0]       shamt_s;
  logic [5:0]       funct_s;
  logic [15:0]      imm16_s;
  logic [25:0]      jaddr_s;

  assign op_s    = instr_r[31:26];
  assign rs_s    = instr_r[25:21];
  assign rt_s    = instr_r[20:16];
  assign rd_s    = instr_r[15:11];
  assign shamt_s = instr_r[10:6];
  assign funct_s = instr_r[5:0];
  assign imm16_s = instr_r[15:0];
  assign jaddr_s = instr_r[25:0];

  logic [IA_W-1:0]  pc_idx_s;
  logic             fetch_oob_s;
  logic [31:0]      pc_plus4_s;
  logic [31:0]      br_tgt_s;
  logic [31:0]      j_tgt_s;
  logic [31:0]      ea_s;
  logic             ea_ok_s;
  logic [DA_W-1:0]  ea_idx_s;
  state_t           done_next_s;
  logic             go_s;

  assign pc_idx_s    = pc_r[IA_W-1:0];
  // 33-bit compare so a PC near 2^32 cannot wrap past the bound.
  assign fetch_oob_s = ({1'b0, pc_r} + 33'd3) >= 33'(IMEM_BYTES);
  assign pc_plus4_s  = pc_r + 32'd4;
  assign br_tgt_s    = pc_plus4_s + {imm_r[29:0], 2'b00};
  assign j_tgt_s     = {pc_r[31:28], jaddr_s, 2'b00};
  assign ea_s        = a_r + imm_r;
  assign ea_ok_s     = ea_s < 32'(DMEM_WORDS);
  assign ea_idx_s    = ea_s[DA_W-1:0];
  // A finishing instruction keeps going only while run is held.
  assign done_next_s = run ? S_FETCH : S_IDLE;

  assign tick_s = (cnt_r == CNT_W'(TICK_DIV - 1));

`ifdef MIPS_SINGLE_STEP_EN
  logic step_q_r;
  logic armed_r;

  // Step edge detector and one-shot arm, only honoured while idle with run low.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      step_q_r <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      step_q_r <= step;
      if (state_r == S_IDLE && tick_s && (run || armed_r)) begin
        armed_r <= 1'b0;
      end else if (state_r == S_IDLE && !run && step && !step_q_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign go_s = run || armed_r;
`else
  assign go_s = run;
`endif

  // Clock-enable divider: counts 0..TICK_DIV-1 and ticks on the last count.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Instruction memory load port; no reset so contents survive reset.
  always_ff @(posedge clk_in) begin
    if (imem_we && (state_r == S_IDLE || state_r == S_HALT) &&
        (32'(imem_addr) < 32'(IMEM_BYTES))) begin
      imem_r[imem_addr] <= imem_wdata;
    end
  end

  kind_t       exec_kind_s;
  logic [31:0] exec_val_s;
  logic [4:0]  exec_dest_s;
  logic [31:0] exec_pc_s;
  logic [31:0] exec_res_s;
  logic        exec_res_en_s;

  // EXEC-stage decode: ALU value, destination, next PC and committed result.
  always_comb begin
    exec_kind_s   = K_DONE;
    exec_val_s    = 32'd0;
    exec_dest_s   = 5'd0;
    exec_pc_s     = pc_plus4_s;
    exec_res_s    = 32'd0;
    exec_res_en_s = 1'b0;
    case (op_s)
      6'h00: begin
        exec_dest_s = rd_s;
        case (funct_s)
          6'h20: begin exec_kind_s = K_WB; exec_val_s = a_r + b_r; end
          6'h22: begin exec_kind_s = K_WB; exec_val_s = a_r - b_r; end
          6'h24: begin exec_kind_s = K_WB; exec_val_s = a_r & b_r; end
          6'h25: begin exec_kind_s = K_WB; exec_val_s = a_r | b_r; end
          6'h27: begin exec_kind_s = K_WB; exec_val_s = ~(a_r | b_r); end
          6'h2A: begin exec_kind_s = K_WB; exec_val_s = {31'd0, (a_r < b_r)}; end
          6'h00: begin exec_kind_s = K_WB; exec_val_s = b_r << shamt_s; end
          6'h02: begin exec_kind_s = K_WB; exec_val_s = b_r >> shamt_s; end
          6'h08: begin exec_kind_s = K_DONE; exec_pc_s = a_r; end
          default: exec_kind_s = K_DONE;
        endcase
        exec_res_s = exec_val_s;
      end
      6'h08: begin
        exec_kind_s = K_WB; exec_dest_s = rt_s; exec_val_s = a_r + imm_r;
        exec_res_s  = exec_val_s;
      end
      6'h0C: begin
        exec_kind_s = K_WB; exec_dest_s = rt_s; exec_val_s = a_r & {16'd0, imm16_s};
        exec_res_s  = exec_val_s;
      end
      6'h0D: begin
        exec_kind_s = K_WB; exec_dest_s = rt_s; exec_val_s = a_r | {16'd0, imm16_s};
        exec_res_s  = exec_val_s;
      end
      6'h0F: begin
        exec_kind_s = K_WB; exec_dest_s = rt_s; exec_val_s = {imm16_s, 16'd0};
        exec_res_s  = exec_val_s;
      end
      6'h23: begin exec_kind_s = K_LD; exec_dest_s = rt_s; end
      6'h2B: begin exec_kind_s = K_ST; end
      6'h04: begin
        exec_res_en_s = 1'b1;
        exec_pc_s     = (a_r == b_r) ? br_tgt_s : pc_plus4_s;
        exec_res_s    = (a_r == b_r) ? br_tgt_s : 32'd0;
      end
      6'h05: begin
        exec_res_en_s = 1'b1;
        exec_pc_s     = (a_r != b_r) ? br_tgt_s : pc_plus4_s;
        exec_res_s    = (a_r != b_r) ? br_tgt_s : 32'd0;
      end
      6'h02: begin
        exec_res_en_s = 1'b1; exec_pc_s = j_tgt_s; exec_res_s = j_tgt_s;
      end
      6'h03: begin
        // jal links through WB but reports the jump target as its result.
        exec_kind_s = K_WB; exec_dest_s = 5'd31; exec_val_s = pc_plus4_s;
        exec_pc_s   = j_tgt_s; exec_res_s = j_tgt_s;
      end
      6'h3F: exec_kind_s = K_SRST;
      6'h3E: exec_kind_s = K_HALT;
      default: exec_kind_s = K_DONE;
    endcase
  end

  // Main FSM with register file, data memory and registered outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      pc_r      <= 32'd0;
      instr_r   <= 32'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      imm_r     <= 32'd0;
      val_r     <= 32'd0;
      wb_res_r  <= 32'd0;
      next_pc_r <= 32'd0;
      dest_r    <= 5'd0;
      result_r  <= 32'd0;
      retire_r  <= 1'b0;
      halted_r  <= 1'b0;
      err_r     <= 1'b0;
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem_r[i] <= 32'd0;
    end else begin
      retire_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          S_IDLE: begin
            if (go_s) state_r <= S_FETCH;
            else      state_r <= S_IDLE;
          end
          S_FETCH: begin
            if (fetch_oob_s) begin
              err_r    <= 1'b1;
              halted_r <= 1'b1;
              state_r  <= S_HALT;
            end else begin
              instr_r <= {imem_r[pc_idx_s], imem_r[pc_idx_s + IA_W'(1)],
                          imem_r[pc_idx_s + IA_W'(2)], imem_r[pc_idx_s + IA_W'(3)]};
              state_r <= S_DECODE;
            end
          end
          S_DECODE: begin
            a_r     <= regs_r[rs_s];
            b_r     <= regs_r[rt_s];
            imm_r   <= {{16{imm16_s[15]}}, imm16_s};
            state_r <= S_EXEC;
          end
          S_EXEC: begin
            val_r     <= exec_val_s;
            wb_res_r  <= exec_res_s;
            dest_r    <= exec_dest_s;
            next_pc_r <= exec_pc_s;
            case (exec_kind_s)
              K_WB:   state_r <= S_WB;
              K_LD:   state_r <= S_MEM;
              K_ST:   state_r <= S_MEM;
              K_DONE: begin
                pc_r     <= exec_pc_s;
                if (exec_res_en_s) result_r <= exec_res_s;
                retire_r <= 1'b1;
                state_r  <= done_next_s;
              end
              K_SRST: begin
                for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
                for (int i = 0; i < DMEM_WORDS; i++) dmem_r[i] <= 32'd0;
                pc_r     <= 32'd0;
                retire_r <= 1'b1;
                state_r  <= done_next_s;
              end
              K_HALT: begin
                halted_r <= 1'b1;
                state_r  <= S_HALT;
              end
              default: state_r <= S_IDLE;
            endcase
          end
          S_MEM: begin
            if (!ea_ok_s) err_r <= 1'b1;
            if (op_s == 6'h23) begin
              // Out-of-range loads return zero.
              val_r    <= ea_ok_s ? dmem_r[ea_idx_s] : 32'd0;
              wb_res_r <= ea_ok_s ? dmem_r[ea_idx_s] : 32'd0;
              state_r  <= S_WB;
            end else begin
              if (ea_ok_s) dmem_r[ea_idx_s] <= b_r;
              result_r <= b_r;
              pc_r     <= pc_plus4_s;
              retire_r <= 1'b1;
              state_r  <= done_next_s;
            end
          end
          S_WB: begin
            if (dest_r != 5'd0) regs_r[dest_r] <= val_r;
            result_r <= wb_res_r;
            pc_r     <= next_pc_r;
            retire_r <= 1'b1;
            state_r  <= done_next_s;
          end
          S_HALT:  state_r <= S_HALT;
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  assign result    = fit_result(result_r);
  assign pc_out    = pc_r;
  assign state_out = state_r;
  assign retire    = retire_r;
  assign halted    = halted_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mips_multicycle_core.sv
`timescale 1ns/1ps
module tb_mips_multicycle_core;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_we = 1'b0;
  logic [6:0]  imem_addr = 7'd0;
  logic [7:0]  imem_wdata = 8'd0;
`ifdef MIPS_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  logic [16:0] r1_result, r4_result;
  logic [31:0] r1_pc, r4_pc;
  logic [2:0]  r1_state, r4_state;
  logic        r1_retire, r4_retire, r1_halted, r4_halted, r1_err, r4_err;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  always #5 clk_in = ~clk_in;

  mips_multicycle_core #(.IMEM_BYTES(96), .DMEM_WORDS(100), .RESULT_W(17), .TICK_DIV(1)) dut1 (
    .clk_in(clk_in), .reset(reset), .run(run),
`ifdef MIPS_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .result(r1_result), .pc_out(r1_pc), .state_out(r1_state),
    .retire(r1_retire), .halted(r1_halted), .err(r1_err));

  mips_multicycle_core #(.IMEM_BYTES(96), .DMEM_WORDS(100), .RESULT_W(17), .TICK_DIV(4)) dut4 (
    .clk_in(clk_in), .reset(reset), .run(run),
`ifdef MIPS_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .result(r4_result), .pc_out(r4_pc), .state_out(r4_state),
    .retire(r4_retire), .halted(r4_halted), .err(r4_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompare_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    run = 1'b0;
    imem_we = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      imem_addr  = 7'(addr + k);
      imem_wdata = w[31 - 8*k -: 8];
      imem_we    = 1'b1;
      @(negedge clk_in);
    end
    imem_we = 1'b0;
  endtask

  // Clocks from the previous sample point to the next dut1 retire pulse.
  task automatic wait_retire(output int n);
    n = 0;
    forever begin
      @(negedge clk_in);
      n++;
      if (r1_retire === 1'b1 || n >= 200) break;
    end
    check("retire_seen", r1_retire, 1'b1);
  endtask

  task automatic wait_state(input bit use4, input logic [2:0] s, input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clk_in);
      n++;
      if (((use4 ? r4_state : r1_state) === s) || n >= 600) break;
    end
    check(tag, use4 ? r4_state : r1_state, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int retires;

    // ---- Program A: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; halt ----
    reset_pulse();
    check("rst_state", r1_state, 3'd0);
    check("rst_pc", r1_pc, 32'd0);
    check("rst_result", r1_result, 17'd0);
    check("rst_retire", r1_retire, 1'b0);
    check("rst_halted", r1_halted, 1'b0);
    check("rst_err", r1_err, 1'b0);
    load_word(0,  32'h20010005);
    load_word(4,  32'h20020007);
    load_word(8,  32'h00221820);
    load_word(12, 32'hF8000000);
    run = 1'b1;
    n = 0;
    retires = 0;
    while (r1_halted !== 1'b1 && n < 100) begin
      @(negedge clk_in);
      n++;
      if (r1_retire === 1'b1) retires++;
    end
    check("A_halted", r1_halted, 1'b1);
    check("A_result", r1_result, 17'd12);
    check("A_retires", retires, 32'd3);
    check("A_pc", r1_pc, 32'd12);
    check("A_state", r1_state, 3'd6);
    check("A_err", r1_err, 1'b0);
    wait_state(1'b1, 3'd6, "A4_halt_state");
    check("A4_result", r4_result, 17'd12);
    check("A4_pc", r4_pc, 32'd12);

    // ---- TICK_DIV=4: addi from FETCH entry to retire is 4 ticks x 4 clk ----
    reset_pulse();
    run = 1'b1;
    wait_state(1'b1, 3'd1, "div4_fetch");
    n = 0;
    forever begin
      @(negedge clk_in);
      n++;
      if (r4_retire === 1'b1 || n >= 100) break;
    end
    check("div4_addi_latency", n, 32'd16);

    // ---- Async reset during EXEC of the second instruction ----
    reset_pulse();
    run = 1'b1;
    wait_retire(n);
    check("pre_rst_result", r1_result, 17'd5);
    wait_state(1'b0, 3'd3, "mid_exec");
    reset = 1'b0;
    #1;
    check("async_rst_state", r1_state, 3'd0);
    check("async_rst_pc", r1_pc, 32'd0);
    check("async_rst_result", r1_result, 17'd0);
    @(negedge clk_in);
    reset = 1'b1;
    wait_state(1'b0, 3'd6, "rerun_halt");
    check("rerun_result", r1_result, 17'd12);

    // ---- Program B: memory access ----
    reset_pulse();
    load_word(0,  32'h200100A5);  // addi r1,r0,0xA5
    load_word(4,  32'hAC010003);  // sw r1,3(r0)
    load_word(8,  32'h8C040003);  // lw r4,3(r0)
    load_word(12, 32'h8C0500C8);  // lw r5,200(r0)
    load_word(16, 32'hF8000000);  // halt
    run = 1'b1;
    wait_retire(n);
    check("B_addi_result", r1_result, 17'h000A5);
    wait_retire(n);
    check("B_sw_latency", n, 32'd4);
    check("B_sw_result", r1_result, 17'h000A5);
    wait_retire(n);
    check("B_lw_latency", n, 32'd5);
    check("B_lw_result", r1_result, 17'h000A5);
    check("B_lw_err", r1_err, 1'b0);
    wait_retire(n);
    check("B_lw_oob_latency", n, 32'd5);
    check("B_lw_oob_result", r1_result, 17'd0);
    check("B_lw_oob_err", r1_err, 1'b1);
    wait_state(1'b0, 3'd6, "B_halt");

    // ---- Program C: r0 handling, nor, branches, jal/jr ----
    reset_pulse();
    load_word(0,  32'h20000009);  // addi r0,r0,9
    load_word(4,  32'h00003020);  // add r6,r0,r0
    load_word(8,  32'h00003827);  // nor r7,r0,r0
    load_word(12, 32'h14000005);  // bne r0,r0,5 (not taken)
    load_word(16, 32'h0C000007);  // jal 7 -> 28
    load_word(20, 32'h1000FFFF);  // beq r0,r0,-1
    load_word(28, 32'h03E00008);  // jr r31 -> 20
    run = 1'b1;
    wait_retire(n);
    wait_retire(n);
    check("C_add_r0_result", r1_result, 17'd0);
    wait_retire(n);
    check("C_nor_result", r1_result, 17'h1FFFF);
    wait_retire(n);
    check("C_bne_latency", n, 32'd3);
    check("C_bne_result", r1_result, 17'd0);
    check("C_bne_pc", r1_pc, 32'd16);
    wait_retire(n);
    check("C_jal_latency", n, 32'd4);
    check("C_jal_result", r1_result, 17'd28);
    check("C_jal_pc", r1_pc, 32'd28);
    wait_retire(n);
    check("C_jr_latency", n, 32'd3);
    check("C_jr_pc", r1_pc, 32'd20);
    wait_retire(n);
    check("C_beq_latency", n, 32'd3);
    check("C_beq_result", r1_result, 17'd20);
    check("C_beq_pc", r1_pc, 32'd20);
    run = 1'b0;
    wait_state(1'b0, 3'd0, "C_idle_after_run_drop");
    check("C_idle_pc", r1_pc, 32'd20);
    check("C_err", r1_err, 1'b0);

    // ---- Program D: nops run off the end of instruction memory ----
    reset_pulse();
    for (int a = 0; a < 96; a += 4) load_word(a, 32'h00000000);
    run = 1'b1;
    wait_state(1'b0, 3'd6, "D_halt_state");
    check("D_err", r1_err, 1'b1);
    check("D_halted", r1_halted, 1'b1);
    check("D_pc", r1_pc, 32'd96);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
